// File: rtl/clock_sel_ctrl_synth.sv
// Glitch-free clock-select controller: gates the downstream clock, settles,
// changes the mux select, settles again and re-enables the clock.
module clock_sel_ctrl_synth #(
  parameter int NUM_CLOCKS    = 2,
  parameter int NUM_CLOCK_SEL = 1,
  parameter int RESET_SEL     = 0,
  parameter int GATE_WAIT     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLOCK_SEL-1:0] sel_req,
  input  logic                     req_valid,
  output logic                     req_ready,
  output logic [NUM_CLOCK_SEL-1:0] clk_sel,
  output logic                     clk_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CNT_W = $clog2(GATE_WAIT + 1);

  localparam logic [2:0] ST_SETTLE   = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_GATE_OFF = 3'd2;
  localparam logic [2:0] ST_SWITCH   = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;

  localparam logic [CNT_W-1:0]         CNT_LOAD  = CNT_W'(GATE_WAIT);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
  localparam logic [NUM_CLOCK_SEL-1:0] SEL_RST   = NUM_CLOCK_SEL'(RESET_SEL);
  localparam logic [NUM_CLOCK_SEL:0]   SEL_LIMIT = (NUM_CLOCK_SEL + 1)'(NUM_CLOCKS);

  logic [2:0]               state_r;
  logic [2:0]               state_nxt_s;
  logic [CNT_W-1:0]         cnt_r;
  logic [CNT_W-1:0]         cnt_nxt_s;
  logic [NUM_CLOCK_SEL-1:0] sel_lat_r;
  logic [NUM_CLOCK_SEL-1:0] sel_lat_nxt_s;
  logic [NUM_CLOCK_SEL-1:0] clk_sel_nxt_s;
  logic                     clk_en_nxt_s;
  logic                     done_nxt_s;
  logic                     err_nxt_s;
  logic                     accept_s;
  logic                     sel_bad_s;
  logic                     cnt_last_s;

  assign accept_s   = req_valid && (state_r == ST_IDLE);
  assign sel_bad_s  = ({1'b0, sel_req} >= SEL_LIMIT);
  // Each timed state lasts exactly GATE_WAIT cycles: loaded with GATE_WAIT, leaves at 1.
  assign cnt_last_s = (cnt_r <= CNT_ONE);

  // Next-state, counter and next-output decode.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    sel_lat_nxt_s = sel_lat_r;
    clk_sel_nxt_s = clk_sel;
    clk_en_nxt_s  = clk_en;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;
    case (state_r)
      ST_SETTLE: begin
        if (cnt_last_s) begin
          state_nxt_s  = ST_IDLE;
          clk_en_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (!accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (sel_bad_s) begin
          state_nxt_s = ST_ACK;
          err_nxt_s   = 1'b1;
        end else if (sel_req == clk_sel) begin
          state_nxt_s = ST_ACK;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s   = ST_GATE_OFF;
          clk_en_nxt_s  = 1'b0;
          cnt_nxt_s     = CNT_LOAD;
          sel_lat_nxt_s = sel_req;
        end
      end
      ST_GATE_OFF: begin
        if (cnt_last_s) begin
          state_nxt_s   = ST_SWITCH;
          clk_sel_nxt_s = sel_lat_r;
          cnt_nxt_s     = CNT_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_SWITCH: begin
        if (cnt_last_s) begin
          state_nxt_s  = ST_IDLE;
          clk_en_nxt_s = 1'b1;
          done_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_ACK: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        // Unreachable encodings fall back to a gated, settling state.
        state_nxt_s  = ST_SETTLE;
        cnt_nxt_s    = CNT_LOAD;
        clk_en_nxt_s = 1'b0;
      end
    endcase
  end

  // State and all outputs are registered; reset forces the gated, settling state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_SETTLE;
      cnt_r     <= CNT_LOAD;
      sel_lat_r <= SEL_RST;
      clk_sel   <= SEL_RST;
      clk_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      sel_lat_r <= sel_lat_nxt_s;
      clk_sel   <= clk_sel_nxt_s;
      clk_en    <= clk_en_nxt_s;
      done      <= done_nxt_s;
      err       <= err_nxt_s;
      req_ready <= (state_nxt_s == ST_IDLE);
      busy      <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_clock_sel_ctrl_synth.sv
// Directed bench for clock_sel_ctrl_synth (NUM_CLOCKS=3, 2-bit select, GATE_WAIT=4).
module tb_clock_sel_ctrl_synth;

  logic       clk;
  logic       rst;
  logic [1:0] sel_req;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] clk_sel;
  logic       clk_en;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests;
  int n_fail;
  int cyc;

  // Packed view of all outputs: {clk_sel, clk_en, req_ready, busy, done, err}.
  logic [6:0] obs;
  logic [6:0] exp_v;
  assign obs = {clk_sel, clk_en, req_ready, busy, done, err};

  clock_sel_ctrl_synth #(
    .NUM_CLOCKS(3), .NUM_CLOCK_SEL(2), .RESET_SEL(0), .GATE_WAIT(4)
  ) dut (
    .clk(clk), .rst(rst), .sel_req(sel_req), .req_valid(req_valid),
    .req_ready(req_ready), .clk_sel(clk_sel), .clk_en(clk_en),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are checked at the falling edge (mid-cycle).
  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) next_cycle();
  endtask

  // Hold reset for a few edges, then release; the current cycle becomes cycle 0.
  task automatic start_seq();
    rst = 1'b1;
    req_valid = 1'b0;
    sel_req = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    sel_req = 2'd2;
    repeat (3) @(negedge clk);
    exp_v = {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      $display("FAIL reset_hold got=%b exp=%b", obs, exp_v);
      n_fail++;
    end
    req_valid = 1'b0;
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c <= 5; c++) begin
      exp_v = {2'd0, (cyc >= 4), (cyc >= 4), (cyc < 4), 1'b0, 1'b0};
      n_tests++;
      if (obs !== exp_v) begin
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
        n_fail++;
      end
      next_cycle();
    end
  endtask

  task automatic test_switch();
    logic [1:0] e_sel;
    logic       e_en;
    logic       e_rdy;
    start_seq();
    goto_cycle(10);
    sel_req = 2'd2;
    req_valid = 1'b1;
    next_cycle();
    while (cyc <= 20) begin
      e_sel = (cyc >= 15) ? 2'd2 : 2'd0;
      e_en  = (cyc >= 19);
      e_rdy = (cyc >= 19);
      exp_v = {e_sel, e_en, e_rdy, !e_rdy, (cyc == 19), 1'b0};
      n_tests++;
      if (obs !== exp_v) begin
        $display("FAIL switch cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
        n_fail++;
      end
      // Garbage selects (including out-of-range 3) with valid held while busy.
      sel_req = 2'(cyc) ^ 2'd1;
      req_valid = (cyc <= 18);
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_same_sel();
    start_seq();
    goto_cycle(10);
    sel_req = 2'd0;
    req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    exp_v = {2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      $display("FAIL same_sel_ack got=%b exp=%b", obs, exp_v);
      n_fail++;
    end
    next_cycle();
    exp_v = {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      $display("FAIL same_sel_idle got=%b exp=%b", obs, exp_v);
      n_fail++;
    end
  endtask

  task automatic test_error();
    start_seq();
    goto_cycle(10);
    sel_req = 2'd3;
    req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    exp_v = {2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp_v) begin
      $display("FAIL error_ack got=%b exp=%b", obs, exp_v);
      n_fail++;
    end
    next_cycle();
    exp_v = {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      $display("FAIL error_idle got=%b exp=%b", obs, exp_v);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    start_seq();
    goto_cycle(10);
    sel_req = 2'd2;
    req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    goto_cycle(13);
    exp_v = {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      $display("FAIL mid_pre_reset got=%b exp=%b", obs, exp_v);
      n_fail++;
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    // Cycle 14 is the first cycle with rst low; enable returns at 18.
    while (cyc <= 24) begin
      exp_v = {2'd0, (cyc >= 18), (cyc >= 18), (cyc < 18), 1'b0, 1'b0};
      n_tests++;
      if (obs !== exp_v) begin
        $display("FAIL mid_reset cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
        n_fail++;
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e_sel;
    logic       e_en;
    logic       e_rdy;
    start_seq();
    goto_cycle(10);
    sel_req = 2'd1;
    req_valid = 1'b1;
    next_cycle();
    sel_req = 2'd2;
    while (cyc <= 30) begin
      e_sel = (cyc >= 24) ? 2'd2 : ((cyc >= 15) ? 2'd1 : 2'd0);
      e_en  = !((cyc >= 11 && cyc <= 18) || (cyc >= 20 && cyc <= 27));
      e_rdy = (cyc == 19) || (cyc >= 28);
      exp_v = {e_sel, e_en, e_rdy, !e_rdy, (cyc == 19) || (cyc == 28), 1'b0};
      n_tests++;
      if (obs !== exp_v) begin
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
        n_fail++;
      end
      if (cyc >= 20) req_valid = 1'b0;
      next_cycle();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    sel_req = 2'd0;
    test_reset();
    test_switch();
    test_same_sel();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
